// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and an eight-digit hex entry register.
// Latency: a clean press is reported within 2 + SCAN_DIV*(4+DEBOUNCE_CNT) clocks; outputs are registered.
// Backpressure: none; key_valid is a one-cycle pulse that the consumer must take when it appears.
//
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held
// (REPEAT_CNT sample ticks between repeat events). Without it, each press yields exactly one event.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous active-low reset
//   row[3:0]   row drive, one-hot active-low (1110 = row 0)
//   col[3:0]   column sense, active-low, asynchronous to clk
//   clr        synchronous clear of value (wins over a coincident key event)
//   key_valid  one-cycle pulse per accepted key event
//   key_code   {row[1:0], col[1:0]} of the last accepted key
//   value      hex entry word, newest digit in [3:0], oldest digit shifted out of [31:28]
module keypad_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_CNT   = 100
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] value
);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  // Synchronizer and divider
  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_sync;
  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic             w_idle;
  logic [1:0]       w_low_col;

  // FSM state and its companion registers
  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_row_idx;
  logic [1:0]       w_row_idx_nxt;
  logic [3:0]       r_pat;
  logic [3:0]       w_pat_nxt;
  logic [1:0]       r_col_idx;
  logic [1:0]       w_col_idx_nxt;
  logic [DEB_W-1:0] r_smp_cnt;
  logic [DEB_W-1:0] w_smp_nxt;
  logic [DEB_W-1:0] r_rel_cnt;
  logic [DEB_W-1:0] w_rel_nxt;
  logic             w_accept;
  logic             w_event;

  // Output registers
  logic             r_key_valid;
  logic [3:0]       r_key_code;
  logic [31:0]      r_value;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  logic [REP_W-1:0] r_rep_cnt;
  logic [REP_W-1:0] w_rep_nxt;
  logic             w_repeat;

  assign w_event = w_accept | w_repeat;
`else
  logic w_unused_repeat;

  assign w_unused_repeat = (REPEAT_CNT != 0);
  assign w_event         = w_accept;
`endif

  assign w_tick = (r_div == DIV_LAST);
  assign w_idle = (r_col_sync == 4'b1111);

  // Lowest-index low column wins when several columns are closed.
  always_comb begin
    w_low_col = 2'd3;
    if (!r_col_sync[2]) w_low_col = 2'd2;
    if (!r_col_sync[1]) w_low_col = 2'd1;
    if (!r_col_sync[0]) w_low_col = 2'd0;
  end

  // Two-flop synchronizer (idles high) and sample-tick divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col_meta <= 4'b1111;
      r_col_sync <= 4'b1111;
      r_div      <= '0;
    end else begin
      r_col_meta <= col;
      r_col_sync <= r_col_meta;
      r_div      <= w_tick ? '0 : r_div + DIV_ONE;
    end
  end

  // Next-state logic. Everything advances only on a sample tick; the row
  // is held fixed outside SCAN so the latched pattern stays meaningful.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_idx_nxt = r_row_idx;
    w_pat_nxt     = r_pat;
    w_col_idx_nxt = r_col_idx;
    w_smp_nxt     = r_smp_cnt;
    w_rel_nxt     = r_rel_cnt;
    w_accept      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_nxt     = r_rep_cnt;
    w_repeat      = 1'b0;
`endif
    if (w_tick) begin
      unique case (r_state)
        ST_SCAN: begin
          if (w_idle) begin
            w_row_idx_nxt = r_row_idx + 2'd1;
          end else begin
            // The detecting tick is not counted; DEBOUNCE_CNT further
            // matching ticks are required to accept.
            w_pat_nxt     = r_col_sync;
            w_col_idx_nxt = w_low_col;
            w_smp_nxt     = '0;
            w_state_nxt   = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (r_col_sync == r_pat) begin
            if (r_smp_cnt == DEB_LAST) begin
              w_accept    = 1'b1;
              w_smp_nxt   = '0;
              w_rel_nxt   = '0;
              w_state_nxt = ST_HOLD;
`ifdef KEYPAD_REPEAT_EN
              w_rep_nxt   = '0;
`endif
            end else begin
              w_smp_nxt = r_smp_cnt + DEB_ONE;
            end
          end else begin
            // Bounce: resume scanning from the row we were parked on.
            w_smp_nxt   = '0;
            w_state_nxt = ST_SCAN;
          end
        end
        ST_HOLD: begin
          if (w_idle) begin
            if (r_rel_cnt == DEB_LAST) begin
              w_rel_nxt   = '0;
              w_state_nxt = ST_SCAN;
            end else begin
              w_rel_nxt = r_rel_cnt + DEB_ONE;
            end
          end else begin
            w_rel_nxt = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          // Only the originally latched pattern keeps the repeat timer running.
          if (r_col_sync == r_pat) begin
            if (r_rep_cnt == REP_LAST) begin
              w_repeat  = 1'b1;
              w_rep_nxt = '0;
            end else begin
              w_rep_nxt = r_rep_cnt + REP_ONE;
            end
          end else begin
            w_rep_nxt = '0;
          end
`endif
        end
        default: begin
          w_state_nxt = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_SCAN;
      r_row_idx <= 2'd0;
      r_pat     <= 4'b1111;
      r_col_idx <= 2'd0;
      r_smp_cnt <= '0;
      r_rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_row_idx <= w_row_idx_nxt;
      r_pat     <= w_pat_nxt;
      r_col_idx <= w_col_idx_nxt;
      r_smp_cnt <= w_smp_nxt;
      r_rel_cnt <= w_rel_nxt;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt <= w_rep_nxt;
`endif
    end
  end

  // Event outputs; clr takes priority over the shift but not over the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_value     <= 32'h0;
    end else begin
      r_key_valid <= w_event;
      if (w_event) begin
        r_key_code <= {r_row_idx, r_col_idx};
      end
      if (clr) begin
        r_value <= 32'h0;
      end else if (w_event) begin
        r_value <= {r_value[27:0], r_row_idx, r_col_idx};
      end
    end
  end

  assign row       = ~(4'b0001 << r_row_idx);
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign value     = r_value;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with a queued scoreboard.
// The stimulus thread pushes each expected key event; a monitor pops and
// compares whenever key_valid is seen.
module tb_keypad_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_CNT   = 5;
  localparam int LAT_MAX      = 2 + SCAN_DIV * (4 + DEBOUNCE_CNT);

`ifdef KEYPAD_REPEAT_EN
  localparam int          A_EXTRA = 4;
  localparam logic [31:0] A_VALUE = 32'h000AAAAA;
`else
  localparam int          A_EXTRA = 0;
  localparam logic [31:0] A_VALUE = 32'h0000000A;
`endif

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        clr;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] value;
  logic [15:0] keys;      // keys[r*4+c] = switch at row r, column c closed
  logic [31:0] exp_value;
  ev_t         sb_q[$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_CNT  (REPEAT_CNT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .clr      (clr),
    .key_valid(key_valid),
    .key_code (key_code),
    .value    (value)
  );

  // Switch matrix: a closed switch pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every key_valid must match the next queued expectation.
  always @(negedge clk) begin
    ev_t e;
    if (reset === 1'b1 && key_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_key_valid: got code %h value %h expected no event", key_code, value);
      end else begin
        e = sb_q.pop_front();
        chk("event_code", {28'h0, key_code}, {28'h0, e.code});
        chk("event_value", value, e.val);
      end
    end
  end

  task automatic expect_key(input logic [3:0] code);
    ev_t e;
    exp_value = {exp_value[27:0], code};
    e.code = code;
    e.val  = exp_value;
    sb_q.push_back(e);
  endtask

  task automatic wait_ticks(input int t);
    repeat (t * SCAN_DIV) @(posedge clk);
    #1;
  endtask

  task automatic wait_kv(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < LAT_MAX + 10; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Returns just after the edge on which row switches to `want`.
  task automatic wait_row_entry(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (row != want) break;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (row == want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic lat_check(input string name, input int n, input bit ok);
    checks++;
    if (!ok || n > LAT_MAX) begin
      failures++;
      $display("FAIL %s: got %0d clocks (seen=%0d) expected <= %0d", name, n, ok, LAT_MAX);
    end
  endtask

  // Press a key code (= r*4+c), hold it hold_ticks after acceptance, release.
  task automatic do_key(input logic [3:0] code, input int hold_ticks, input int extra);
    int n;
    bit ok;
    expect_key(code);
    for (int i = 0; i < extra; i++) expect_key(code);
    keys       = '0;
    keys[code] = 1'b1;
    wait_kv(n, ok);
    lat_check("press_latency", n, ok);
    wait_ticks(hold_ticks);
    keys = '0;
    wait_ticks(6);
  endtask

  initial begin
    int  n;
    bit  ok;
    logic [3:0] er;

    reset     = 1'b0;
    clr       = 1'b0;
    keys      = '0;
    exp_value = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_row", {28'h0, row}, 32'he);
    chk("reset_key_valid", {31'h0, key_valid}, 32'h0);
    chk("reset_key_code", {28'h0, key_code}, 32'h0);
    chk("reset_value", value, 32'h0);

    // Idle rotation: row steps every SCAN_DIV clocks
    @(negedge clk) reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      er = ~(4'b0001 << ((k / 4) % 4));
      chk("idle_row", {28'h0, row}, {28'h0, er});
    end
    chk("idle_value", value, 32'h0);

    // Row 2 / col 1, then row 0 / col 3
    do_key(4'h9, 2, 0);
    chk("value_after_9", value, 32'h00000009);
    do_key(4'h3, 2, 0);
    chk("value_after_93", value, 32'h00000093);

    // Bounce on row 1 / col 0: closed 1 tick, open, closed 2 ticks
    wait_row_entry(4'b1101, ok);
    chk("bounce_row_entry1", {31'h0, ok}, 32'h1);
    keys[4] = 1'b1;
    repeat (SCAN_DIV) @(posedge clk);
    #1;
    keys = '0;
    wait_row_entry(4'b1101, ok);
    chk("bounce_row_entry2", {31'h0, ok}, 32'h1);
    keys[4] = 1'b1;
    repeat (2 * SCAN_DIV) @(posedge clk);
    #1;
    keys = '0;
    wait_row_entry(4'b1101, ok);
    chk("bounce_back_to_scan", {31'h0, ok}, 32'h1);
    chk("bounce_value", value, 32'h00000093);

    // clr pulse, then nine presses 1..9
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    exp_value = 32'h0;
    chk("clr_value", value, 32'h0);
    for (int k = 1; k <= 9; k++) do_key(4'(k), 1, 0);
    chk("nine_digits", value, 32'h23456789);

    // clr coincident with acceptance of key 5 (row 1 / col 1):
    // detect at row-entry + 1 tick, accept DEBOUNCE_CNT ticks later.
    wait_row_entry(4'b1101, ok);
    chk("clr_row_entry", {31'h0, ok}, 32'h1);
    begin
      ev_t e;
      exp_value = 32'h0;
      e.code = 4'h5;
      e.val  = 32'h0;
      sb_q.push_back(e);
    end
    keys[5] = 1'b1;
    repeat ((1 + DEBOUNCE_CNT) * SCAN_DIV - 1) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_accept_valid", {31'h0, key_valid}, 32'h1);
    chk("clr_accept_code", {28'h0, key_code}, 32'h5);
    chk("clr_accept_value", value, 32'h0);
    wait_ticks(2);
    keys = '0;
    wait_ticks(6);

    // Key A held 22 ticks after acceptance (auto-repeat when enabled)
    do_key(4'hA, 22, A_EXTRA);
    chk("hold_A_value", value, A_VALUE);

    // Two columns on row 3 resolve to col 0; extra key in HOLD ignored
    begin
      keys     = '0;
      keys[12] = 1'b1;
      keys[14] = 1'b1;
      expect_key(4'hC);
      wait_kv(n, ok);
      lat_check("multi_latency", n, ok);
      wait_ticks(2);
      keys[15] = 1'b1;
      wait_ticks(3);
      keys = '0;
      wait_ticks(6);
    end
    chk("multi_value", value, exp_value);

    // Reset in the middle of DEBOUNCE (key 7 = row 1 / col 3)
    wait_row_entry(4'b1101, ok);
    chk("abort_row_entry", {31'h0, ok}, 32'h1);
    keys[7] = 1'b1;
    repeat (SCAN_DIV + 2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    keys = '0;
    chk("abort_deb_valid", {31'h0, key_valid}, 32'h0);
    chk("abort_deb_code", {28'h0, key_code}, 32'h0);
    chk("abort_deb_value", value, 32'h0);
    exp_value = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      er = ~(4'b0001 << ((k / 4) % 4));
      chk("restart_row", {28'h0, row}, {28'h0, er});
    end

    // Reset in the middle of HOLD (key 6 = row 1 / col 2)
    expect_key(4'h6);
    keys[6] = 1'b1;
    wait_kv(n, ok);
    lat_check("hold_abort_latency", n, ok);
    wait_ticks(1);
    reset = 1'b0;
    #1;
    keys = '0;
    exp_value = 32'h0;
    chk("abort_hold_value", value, 32'h0);
    chk("abort_hold_row", {28'h0, row}, 32'he);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    wait_ticks(10);
    chk("post_abort_value", value, 32'h0);

    chk("scoreboard_drained", sb_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
